imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Upstream of the single-cycle CPU skeleton. After reset it holds the core in reset,
//  accepts a program as a valid/ready word stream and writes it into instruction
//  memory from address 0. It then counts a fixed release delay and deasserts the core
//  reset. It replaces the fixed-image imem load so that benches and boards can boot
//  arbitrary programs.
// PARAMETERS
//  ADDR_WIDTH     12    imem word-address width (matches address_imem)
//  DATA_WIDTH     32    instruction word width
//  RELEASE_DELAY  4     cycles between the last imem write and core_reset deassert (>=1)
// PORTS
//  clock          in   1           system clock; all state on posedge
//  reset          in   1           asynchronous, active-low (0 = reset)
//  start          in   1           one-cycle pulse; begins a load when IDLE
//  in_valid       in   1           source has a word
//  in_data        in   DATA_WIDTH  instruction word
//  in_last        in   1           qualifies in_data as the final word
//  in_ready       out  1           loader accepts a word this cycle
//  imem_address   out  ADDR_WIDTH  imem write address
//  imem_data      out  DATA_WIDTH  imem write data
//  imem_wren      out  1           imem write enable
//  core_reset     out  1           active-high reset to skeleton
//  boot_done      out  1           program loaded and core released
//  load_error     out  1           image exceeded 2**ADDR_WIDTH words
//  word_count     out  ADDR_WIDTH+1  words written in current/last load
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; in_ready=0, imem_wren=0, imem_address=0,
//   imem_data=0, core_reset=1, boot_done=0, load_error=0, word_count=0.
//  FSM: IDLE -start-> LOAD -accept&in_last-> RELEASE -delay done-> RUN; LOAD -overflow-> ERROR.
//   IDLE: in_ready=0. On start, clear word_count/load_error and go to LOAD.
//   LOAD: in_ready=1 (Moore; no dependence on in_valid). Accept = in_valid & in_ready.
//    On accept, next cycle: imem_wren=1, imem_address=word_count[ADDR_WIDTH-1:0],
//    imem_data=in_data, word_count+=1. The write has one cycle of latency after accept;
//    imem_wren is a single-cycle pulse per accepted word.
//    in_valid=0 leaves all state unchanged. Back-to-back accepts are allowed, 1 word/cycle.
//    in_last on the accept that fills address 2**ADDR_WIDTH-1 is legal -> RELEASE.
//    Accept without in_last when word_count==2**ADDR_WIDTH-1 -> that word is still
//    written, then ERROR.
//   RELEASE: in_ready=0. Counter runs RELEASE_DELAY cycles, counted from the cycle after
//    the final imem_wren. Then core_reset goes 0 and boot_done goes 1 on the same edge.
//   RUN: core_reset=0, boot_done=1, in_ready=0; start ignored; only reset leaves RUN.
//   ERROR: load_error=1, core_reset=1, in_ready=0. start -> clear load_error and
//    word_count, go to LOAD.
//  start outside IDLE/ERROR is ignored. in_last without in_valid is ignored.
//  Reset mid-load: immediate return to reset values. Partially written imem is
//   not scrubbed.
//  word_count saturates at 2**ADDR_WIDTH and holds its final value in RUN/ERROR.
// STRUCTURE
//  Shared package/header `boot_defs`: state encoding localparams
//   (IDLE, LOAD, RELEASE, RUN, ERROR) and the ADDR_WIDTH/DATA_WIDTH defaults, also
//   used by skeleton and its bench.
//  One natural sub-module: `boot_delay_counter` (load/enable/done down-counter for
//   RELEASE). Everything else stays in a single FSM + datapath register block.
// TESTING
//  1 Reset low 2 cycles, high -> all outputs at reset values; core_reset=1, in_ready=0.
//  2 start; stream 3 words 0x20010005, 0x20020003, 0x00221820 (last on 3rd) with
//    in_valid held -> imem_wren at addr 0,1,2 on consecutive cycles; word_count=3;
//    core_reset falls exactly 4 cycles after the final write; boot_done=1.
//  3 Same image, in_valid toggled 1,0,1,0,1 -> writes only on accepted cycles;
//    addresses 0,1,2 with no gaps in address; no write on idle cycles.
//  4 ADDR_WIDTH=4: stream 16 words with last on the 16th -> RUN, no error. Stream 17
//    words with no last -> 16 writes (addr 0..15), then ERROR, load_error=1,
//    core_reset stays 1, in_ready=0.
//  5 Pull reset low after 2 of 5 words -> outputs return to reset values
//    asynchronously. After release, start and a full reload -> addr restarts at 0.
//  6 In RUN, pulse start and drive in_valid=1 -> no writes, boot_done stays 1.
//    Bench then runs skeleton with loaded image and checks the expected
//    regfile writes ($3=8).

Source files
------------

// File: rtl/boot_defs_pkg.sv
// Shared boot definitions: loader state encoding and default widths,
// common to the boot loader, the CPU skeleton and their benches.
package boot_defs;

  localparam int unsigned BOOT_ADDR_WIDTH    = 12;
  localparam int unsigned BOOT_DATA_WIDTH    = 32;
  localparam int unsigned BOOT_RELEASE_DELAY = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    ERROR   = 3'd4
  } boot_state_t;

endpackage

// File: rtl/boot_delay_counter.sv
// Load/enable down-counter timing the gap between the last imem write and
// core release; done_c is high once the count has drained to zero.
module boot_delay_counter #(
  parameter int unsigned DELAY = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic done_c
);

  localparam int unsigned CW = $clog2(DELAY + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(DELAY);
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: holds the core in reset, streams a program into imem from
// address 0, waits a fixed delay, then releases the core.
module imem_boot_loader
  import boot_defs::*;
#(
  parameter int unsigned ADDR_WIDTH    = BOOT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = BOOT_DATA_WIDTH,
  parameter int unsigned RELEASE_DELAY = BOOT_RELEASE_DELAY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [DATA_WIDTH-1:0] imem_data,
  output logic                  imem_wren,
  output logic                  core_reset,
  output logic                  boot_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_SLOT = (ADDR_WIDTH + 1)'(DEPTH - 1);

  boot_state_t           state, state_d;
  logic                  in_ready_d, imem_wren_d, core_reset_d, boot_done_d, load_error_d;
  logic [ADDR_WIDTH-1:0] imem_address_d;
  logic [DATA_WIDTH-1:0] imem_data_d;
  logic [ADDR_WIDTH:0]   word_count_d;
  logic                  cnt_load, cnt_enable, cnt_done_c;
  logic                  accept_c;

  assign accept_c = in_valid & in_ready;

  boot_delay_counter #(
    .DELAY (RELEASE_DELAY)
  ) u_delay (
    .clock  (clock),
    .reset  (reset),
    .load   (cnt_load),
    .enable (cnt_enable),
    .done_c (cnt_done_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d        = state;
    imem_wren_d    = 1'b0;
    imem_address_d = imem_address;
    imem_data_d    = imem_data;
    word_count_d   = word_count;
    load_error_d   = load_error;
    core_reset_d   = core_reset;
    boot_done_d    = boot_done;
    cnt_load       = 1'b0;
    cnt_enable     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          word_count_d = '0;
          load_error_d = 1'b0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (accept_c) begin
          imem_wren_d    = 1'b1;
          imem_address_d = word_count[ADDR_WIDTH-1:0];
          imem_data_d    = in_data;
          word_count_d   = word_count + (ADDR_WIDTH + 1)'(1);
          if (in_last) begin
            state_d  = RELEASE;
            cnt_load = 1'b1;
          end else if (word_count == LAST_SLOT) begin
            // Image did not end in the last slot: it cannot fit.
            state_d      = ERROR;
            load_error_d = 1'b1;
          end
        end
      end
      RELEASE: begin
        cnt_enable = 1'b1;
        if (cnt_done_c) begin
          state_d      = RUN;
          core_reset_d = 1'b0;
          boot_done_d  = 1'b1;
        end
      end
      RUN: begin
      end
      ERROR: begin
        if (start) begin
          word_count_d = '0;
          load_error_d = 1'b0;
          state_d      = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      imem_wren    <= 1'b0;
      imem_address <= '0;
      imem_data    <= '0;
      core_reset   <= 1'b1;
      boot_done    <= 1'b0;
      load_error   <= 1'b0;
      word_count   <= '0;
    end else begin
      state        <= state_d;
      in_ready     <= in_ready_d;
      imem_wren    <= imem_wren_d;
      imem_address <= imem_address_d;
      imem_data    <= imem_data_d;
      core_reset   <= core_reset_d;
      boot_done    <= boot_done_d;
      load_error   <= load_error_d;
      word_count   <= word_count_d;
    end
  end

endmodule
